// File: rtl/cache_pkg.sv
// Shared widths, line-field layout and request encodings for the set-associative cache datapath.
package cache_pkg;

    localparam int ADDR_WIDTH = 32;

    // Packed line layout: {block, tag, dirty, valid}
    localparam int VALID_BIT = 0;
    localparam int DIRTY_BIT = 1;
    localparam int TAG_LSB   = 2;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    function automatic int calc_num_sets(input int num_blocks, input int num_ways);
        return num_blocks / num_ways;
    endfunction

    function automatic int calc_index_width(input int num_blocks, input int num_ways);
        return $clog2(num_blocks / num_ways);
    endfunction

    function automatic int calc_offset_width(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int calc_tag_width(input int num_blocks, input int num_ways,
                                          input int words_per_block);
        return ADDR_WIDTH - calc_index_width(num_blocks, num_ways)
                          - calc_offset_width(words_per_block);
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU state: NUM_WAYS-1 bits per set, each bit pointing toward the victim half.
module plru_tree
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 32,
    parameter int NUM_WAYS = 2,
    localparam int INDEX_WIDTH = $clog2(NUM_SETS),
    localparam int WAY_WIDTH   = $clog2(NUM_WAYS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] set_index,
    input  logic                   touch,
    input  logic [WAY_WIDTH-1:0]   touch_way,
    output logic [WAY_WIDTH-1:0]   victim
);

    localparam int NODES = NUM_WAYS - 1;

    logic [NODES-1:0] tree_bits [NUM_SETS];
    logic [NODES-1:0] cur_bits;
    logic [NODES-1:0] next_bits;

    assign cur_bits = tree_bits[set_index];

    // Nodes are heap-numbered from 1; bit value 0 steers toward the lower half.
    always_comb begin
        int node;
        node = 1;
        for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
            node = 2 * node + int'(cur_bits[WAY_WIDTH'(node - 1)]);
        end
        victim = WAY_WIDTH'(node - NUM_WAYS);
    end

    always_comb begin
        int  node;
        logic dir;
        next_bits = cur_bits;
        node      = 1;
        for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
            dir = touch_way[WAY_WIDTH-1-lvl];
            next_bits[WAY_WIDTH'(node - 1)] = ~dir;
            node = 2 * node + int'(dir);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                tree_bits[s] <= '0;
            end
        end else if (touch) begin
            tree_bits[set_index] <= next_bits;
        end
    end

endmodule

// File: rtl/cache_memory.sv
// Storage and datapath of an N-way set-associative write-back cache: tag compare, word access,
// victim write-back and line refill, driven by an external controller's enables.
module cache_memory
    import cache_pkg::*;
#(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 64,
    parameter int NUM_WAYS        = 2,
    localparam int BLOCK_SIZE   = WORDS_PER_BLOCK * WORD_SIZE,
    localparam int NUM_SETS     = calc_num_sets(NUM_BLOCKS, NUM_WAYS),
    localparam int INDEX_WIDTH  = calc_index_width(NUM_BLOCKS, NUM_WAYS),
    localparam int OFFSET_WIDTH = calc_offset_width(WORDS_PER_BLOCK),
    localparam int TAG_WIDTH    = calc_tag_width(NUM_BLOCKS, NUM_WAYS, WORDS_PER_BLOCK)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TAG_WIDTH-1:0]    tag,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic [OFFSET_WIDTH-1:0] blk_offset,
    input  logic                    req_type,
    input  logic                    read_en_cache,
    input  logic                    write_en_cache,
    input  logic                    read_en_mem,
    input  logic                    write_en_mem,
    input  logic [BLOCK_SIZE-1:0]   data_in_mem,
    input  logic [WORD_SIZE-1:0]    data_in,
    output logic [BLOCK_SIZE-1:0]   dirty_block_out,
    output logic                    hit,
    output logic [WORD_SIZE-1:0]    data_out,
    output logic                    dirty_bit
);

    localparam int WAY_WIDTH  = $clog2(NUM_WAYS);
    localparam int BLOCK_LSB  = TAG_LSB + TAG_WIDTH;
    localparam int LINE_WIDTH = BLOCK_LSB + BLOCK_SIZE;

    logic [LINE_WIDTH-1:0] cache [NUM_SETS][NUM_WAYS];

    logic [NUM_WAYS-1:0]  way_valid;
    logic [NUM_WAYS-1:0]  way_dirty;
    logic [NUM_WAYS-1:0]  way_match;
    logic [WAY_WIDTH-1:0] hit_way;
    logic [WAY_WIDTH-1:0] free_way;
    logic                 has_free;
    logic [WAY_WIDTH-1:0] plru_victim;
    logic [WAY_WIDTH-1:0] accessed_way;

    logic do_refill;
    logic do_writeback;
    logic do_write;
    logic do_read;
    logic plru_touch;
    int   word_lsb;

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_valid[w] = cache[index][w][VALID_BIT];
            way_dirty[w] = cache[index][w][DIRTY_BIT];
            way_match[w] = cache[index][w][VALID_BIT]
                           && (cache[index][w][BLOCK_LSB-1:TAG_LSB] == tag);
        end
    end

    // Lowest-numbered match / invalid way wins, so the refill target is deterministic.
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        has_free = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                hit_way = WAY_WIDTH'(w);
            end
            if (!way_valid[w]) begin
                free_way = WAY_WIDTH'(w);
                has_free = 1'b1;
            end
        end
    end

    assign hit          = |way_match;
    assign accessed_way = hit ? hit_way : (has_free ? free_way : plru_victim);
    assign dirty_bit    = way_valid[accessed_way] && way_dirty[accessed_way];

    assign do_refill    = read_en_mem && write_en_cache;
    assign do_writeback = !do_refill && read_en_cache && write_en_mem;
    assign do_write     = !do_refill && !do_writeback && write_en_cache
                          && (req_type == REQ_WRITE) && hit;
    assign do_read      = !do_refill && !do_writeback && !do_write && read_en_cache
                          && (req_type == REQ_READ) && hit;
    assign plru_touch   = do_refill || do_write || do_read;
    assign word_lsb     = BLOCK_LSB + int'(blk_offset) * WORD_SIZE;

    plru_tree #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .clk       (clk),
        .rst       (rst),
        .set_index (index),
        .touch     (plru_touch),
        .touch_way (accessed_way),
        .victim    (plru_victim)
    );

    // Tag and block contents are left untouched by reset; only the state bits are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    cache[s][w][VALID_BIT] <= 1'b0;
                    cache[s][w][DIRTY_BIT] <= 1'b0;
                end
            end
            data_out        <= '0;
            dirty_block_out <= '0;
        end else if (do_refill) begin
            cache[index][accessed_way] <= {data_in_mem, tag, 1'b0, 1'b1};
        end else if (do_writeback) begin
            dirty_block_out <= cache[index][accessed_way][LINE_WIDTH-1:BLOCK_LSB];
        end else if (do_write) begin
            cache[index][accessed_way][word_lsb +: WORD_SIZE] <= data_in;
            cache[index][accessed_way][DIRTY_BIT]             <= 1'b1;
        end else if (do_read) begin
            data_out <= cache[index][accessed_way][word_lsb +: WORD_SIZE];
        end
    end

endmodule

// File: tb/tb_cache_memory.sv
// Randomized and directed bench for cache_memory against a per-set way/tag/block model.
module tb_cache_memory;

    localparam int TW = 25;
    localparam int IW = 5;
    localparam int OW = 2;
    localparam int NS = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] tag = '0;
    logic [IW-1:0] index = '0;
    logic [OW-1:0] blk_offset = '0;
    logic          req_type = 1'b0;
    logic          read_en_cache = 1'b0;
    logic          write_en_cache = 1'b0;
    logic          read_en_mem = 1'b0;
    logic          write_en_mem = 1'b0;
    logic [127:0]  data_in_mem = '0;
    logic [31:0]   data_in = '0;
    logic [127:0]  dirty_block_out;
    logic          hit;
    logic [31:0]   data_out;
    logic          dirty_bit;

    int total = 0;
    int bad   = 0;

    bit            m_valid  [NS][2];
    bit            m_dirty  [NS][2];
    logic [TW-1:0] m_tag    [NS][2];
    logic [127:0]  m_block  [NS][2];
    int            m_victim [NS];
    logic [31:0]   m_dout;
    logic [127:0]  m_dbo;

    logic [TW-1:0] pool [4] = '{25'h0000A, 25'h1F00B, 25'h0C0FF, 25'h155555};

    cache_memory dut (
        .clk             (clk),
        .rst             (rst),
        .tag             (tag),
        .index           (index),
        .blk_offset      (blk_offset),
        .req_type        (req_type),
        .read_en_cache   (read_en_cache),
        .write_en_cache  (write_en_cache),
        .read_en_mem     (read_en_mem),
        .write_en_mem    (write_en_mem),
        .data_in_mem     (data_in_mem),
        .data_in         (data_in),
        .dirty_block_out (dirty_block_out),
        .hit             (hit),
        .data_out        (data_out),
        .dirty_bit       (dirty_bit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int s = 0; s < NS; s++) begin
            m_victim[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_dout = '0;
        m_dbo  = '0;
    endtask

    // Hit way if present, else first empty way, else the way the last touch did not use.
    task automatic model_find(input int s, input logic [TW-1:0] t, output bit h, output int w);
        h = 1'b0;
        w = -1;
        for (int i = 0; i < 2; i++) begin
            if (m_valid[s][i] && m_tag[s][i] == t) begin
                h = 1'b1;
                w = i;
            end
        end
        if (!h) begin
            for (int i = 1; i >= 0; i--) begin
                if (!m_valid[s][i]) w = i;
            end
            if (w < 0) w = m_victim[s];
        end
    endtask

    task automatic do_reset(input bit with_enables);
        rst = 1'b1;
        if (with_enables) begin
            read_en_cache  = 1'b1;
            write_en_cache = 1'b1;
            read_en_mem    = 1'b1;
            write_en_mem   = 1'b1;
        end
        step();
        rst            = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        model_reset();
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_dirty_block", dirty_block_out, 128'h0);
        chk("rst_hit", hit, 1'b0);
    endtask

    // One controller-style transaction: optional idle miss probe, write-back, refill, then access.
    task automatic run_access(input int s, input logic [TW-1:0] t, input int off, input bit wr,
                              input logic [31:0] wd, input logic [127:0] fill, input bit probe);
        bit h;
        int w;
        bit vd;
        index      = IW'(s);
        tag        = t;
        blk_offset = OW'(off);
        req_type   = wr;
        #1;
        model_find(s, t, h, w);
        vd = m_valid[s][w] && m_dirty[s][w];
        chk("hit", hit, h);
        chk("dirty_bit", dirty_bit, vd);
        chk("accessed_way", dut.accessed_way, w);
        if (!h) begin
            if (probe) begin
                data_in = wd;
                if (wr) write_en_cache = 1'b1;
                else    read_en_cache  = 1'b1;
                step();
                write_en_cache = 1'b0;
                read_en_cache  = 1'b0;
                chk("miss_hold_data", data_out, m_dout);
                chk("miss_hold_hit", hit, 1'b0);
                chk("miss_hold_dirty", dirty_bit, vd);
            end
            if (vd) begin
                read_en_cache = 1'b1;
                write_en_mem  = 1'b1;
                step();
                read_en_cache = 1'b0;
                write_en_mem  = 1'b0;
                m_dbo = m_block[s][w];
                chk("writeback", dirty_block_out, m_dbo);
            end
            data_in_mem    = fill;
            read_en_mem    = 1'b1;
            write_en_cache = 1'b1;
            step();
            read_en_mem    = 1'b0;
            write_en_cache = 1'b0;
            m_valid[s][w] = 1'b1;
            m_dirty[s][w] = 1'b0;
            m_tag[s][w]   = t;
            m_block[s][w] = fill;
            m_victim[s]   = 1 - w;
            chk("refill_hit", hit, 1'b1);
            chk("refill_way", dut.accessed_way, w);
        end
        if (wr) begin
            data_in        = wd;
            write_en_cache = 1'b1;
            step();
            write_en_cache = 1'b0;
            m_block[s][w][off*32 +: 32] = wd;
            m_dirty[s][w] = 1'b1;
            m_victim[s]   = 1 - w;
            chk("write_dirty", dirty_bit, 1'b1);
        end else begin
            read_en_cache = 1'b1;
            step();
            read_en_cache = 1'b0;
            m_dout      = m_block[s][w][off*32 +: 32];
            m_victim[s] = 1 - w;
            chk("read_data", data_out, m_dout);
        end
    endtask

    initial begin
        logic [127:0] line_a;
        logic [127:0] line_b;
        step();
        step();
        rst = 1'b0;
        model_reset();
        #1;
        chk("init_hit", hit, 1'b0);
        chk("init_dirty_bit", dirty_bit, 1'b0);
        chk("init_data_out", data_out, 32'h0);
        chk("init_dirty_block", dirty_block_out, 128'h0);

        // Load set 0 and exercise read hit / clean miss
        run_access(0, 25'h1ABCDE, 2, 1'b0, 32'h0,
                   128'hDEADBEEF_55667788_11223344_AABBCCDD, 1'b0);
        chk("t1_fill_read", data_out, 32'h55667788);
        run_access(0, 25'h0C0FF, 0, 1'b0, 32'h0, 128'h01010101_02020202_03030303_04040404, 1'b0);
        index = '0; tag = 25'h1ABCDE; blk_offset = 2'd2; req_type = 1'b0;
        #1;
        chk("t1_hit", hit, 1'b1);
        chk("t1_way", dut.accessed_way, 1'b0);
        run_access(0, 25'h1ABCDE, 2, 1'b0, 32'h0, 128'h0, 1'b0);
        chk("t1_data", data_out, 32'h55667788);

        tag = 25'h12345;
        #1;
        chk("t2_miss", hit, 1'b0);
        chk("t2_clean", dirty_bit, 1'b0);
        line_a = 128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321;
        run_access(0, 25'h12345, 0, 1'b0, 32'h0, line_a, 1'b1);
        chk("t2_line", dut.cache[0][1], {line_a, 25'h12345, 2'b01});
        chk("t2_data", data_out, 32'h87654321);

        // Dirty victim write-back in set 1
        line_b = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        run_access(1, 25'h2AAAA, 0, 1'b1, 32'hDDDDDDDD, line_b, 1'b0);
        run_access(1, 25'h2BBBB, 3, 1'b0, 32'h0, 128'h11111111_22222222_33333333_44444444, 1'b0);
        run_access(1, 25'h2BBBB, 1, 1'b0, 32'h0, 128'h0, 1'b0);
        chk("t3_way1", dut.accessed_way, 1'b1);
        index = IW'(1); tag = 25'h2CCCC; req_type = 1'b0;
        #1;
        chk("t3_miss", hit, 1'b0);
        chk("t3_dirty", dirty_bit, 1'b1);
        chk("t3_way0", dut.accessed_way, 1'b0);
        run_access(1, 25'h2CCCC, 0, 1'b0, 32'h0, 128'hFEEDFACE_DEADBEAF_CAFEBABE_12345678, 1'b1);
        chk("t3_wb", dirty_block_out, line_b);
        chk("t3_data", data_out, 32'h12345678);

        // Write hit marks the line dirty
        run_access(0, 25'h1ABCDE, 1, 1'b1, 32'h0BADF00D, 128'h0, 1'b0);
        chk("t4_dirty", dut.cache[0][0][1], 1'b1);
        run_access(0, 25'h1ABCDE, 1, 1'b0, 32'h0, 128'h0, 1'b0);
        chk("t4_data", data_out, 32'h0BADF00D);

        // Reset with every enable raised
        index = '0; tag = 25'h1ABCDE; req_type = 1'b0;
        do_reset(1'b1);
        tag = 25'h12345;
        #1;
        chk("t5_hit_a", hit, 1'b0);
        index = IW'(1); tag = 25'h2CCCC;
        #1;
        chk("t5_hit_b", hit, 1'b0);
        chk("t5_dirty", dirty_bit, 1'b0);

        // Invalid ways fill lowest first
        index = IW'(3); tag = 25'h00777;
        #1;
        chk("t6_way0", dut.accessed_way, 1'b0);
        run_access(3, 25'h00777, 0, 1'b0, 32'h0, 128'h5, 1'b0);
        tag = 25'h00888;
        #1;
        chk("t6_way1", dut.accessed_way, 1'b1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                run_access($urandom_range(0, 3), pool[$urandom_range(0, 3)],
                           $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom,
                           {$urandom, $urandom, $urandom, $urandom},
                           $urandom_range(0, 3) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
